// File: rtl/intr_ctrl.sv
// 8-source priority interrupt controller on an MCU port bus (MASK / PEND-EOI / STATUS-ACK).
// Optional REQ acknowledge timeout with sticky TOF flag is enabled by defining IC_TIMEOUT_EN.
module intr_ctrl #(
  parameter logic [7:0] BASE_ID = 8'hE0,
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic       IC_CLK,
  input  logic       IC_RST_N,
  input  logic [7:0] IC_IRQ,
  input  logic [7:0] IC_PORT_ID,
  input  logic [7:0] IC_DIN,
  input  logic       IC_IO_STRB,
  output logic [7:0] IC_DOUT,
  output logic       IC_INTR
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_SERV = 2'b10,
    ST_BAD  = 2'b11
  } state_t;

  localparam logic [7:0] ADDR_MASK = BASE_ID;
  localparam logic [7:0] ADDR_PEND = BASE_ID + 8'd1;
  localparam logic [7:0] ADDR_STAT = BASE_ID + 8'd2;

  logic [7:0] r_sync1, r_sync2, r_prev;
  logic [2:0] r_arm;
  logic [7:0] r_mask, r_pend;
  logic [2:0] r_cur;
  state_t     r_st;
  logic       r_intr;

  state_t     w_st_next;
  logic [2:0] w_cur_next;
  logic [7:0] w_edge, w_pend_next, w_req;
  logic [2:0] w_lowest;
  logic       w_wr_mask, w_wr_eoi, w_wr_stat;
  logic       w_tof;
  logic       w_tof_set;

  assign w_wr_mask = IC_IO_STRB && (IC_PORT_ID == ADDR_MASK);
  assign w_wr_eoi  = IC_IO_STRB && (IC_PORT_ID == ADDR_PEND);
  assign w_wr_stat = IC_IO_STRB && (IC_PORT_ID == ADDR_STAT);

  // r_arm holds off edge detection until the synchronizer and r_prev carry real
  // samples, so lines already high at reset release are not seen as edges.
  assign w_edge      = r_arm[2] ? (r_sync2 & ~r_prev) : 8'h00;
  assign w_pend_next = (r_pend & ~(w_wr_eoi ? IC_DIN : 8'h00)) | w_edge;
  assign w_req       = r_pend & r_mask;

  always_comb begin
    w_lowest = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_req[i]) w_lowest = 3'(i);
    end
  end

`ifdef IC_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_next;
  logic       r_tof;
  assign w_tof = r_tof;
`else
  assign w_tof = 1'b0;
`endif

  always_comb begin
    w_st_next  = r_st;
    w_cur_next = r_cur;
    w_tof_set  = 1'b0;
`ifdef IC_TIMEOUT_EN
    w_cnt_next = r_cnt;
`endif
    case (r_st)
      ST_IDLE: begin
        if (|w_req) begin
          w_st_next  = ST_REQ;
          w_cur_next = w_lowest;
`ifdef IC_TIMEOUT_EN
          w_cnt_next = 8'd0;
`endif
        end
      end
      ST_REQ: begin
        if (w_wr_stat) begin
          w_st_next = ST_SERV;
        end else if (!r_mask[r_cur]) begin
          w_st_next = ST_IDLE;
        end
`ifdef IC_TIMEOUT_EN
        else begin
          w_cnt_next = r_cnt + 8'd1;
          if (w_cnt_next == TIMEOUT) begin
            w_st_next = ST_IDLE;
            w_tof_set = 1'b1;
          end
        end
`endif
      end
      ST_SERV: begin
        if (w_wr_eoi) w_st_next = ST_IDLE;
      end
      default: w_st_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge IC_CLK or negedge IC_RST_N) begin
    if (!IC_RST_N) begin
      r_sync1 <= 8'h00;
      r_sync2 <= 8'h00;
      r_prev  <= 8'h00;
      r_arm   <= 3'b000;
      r_mask  <= 8'h00;
      r_pend  <= 8'h00;
      r_cur   <= 3'd0;
      r_st    <= ST_IDLE;
      r_intr  <= 1'b0;
    end else begin
      r_sync1 <= IC_IRQ;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_arm   <= {r_arm[1:0], 1'b1};
      if (w_wr_mask) r_mask <= IC_DIN;
      r_pend  <= w_pend_next;
      r_cur   <= w_cur_next;
      r_st    <= w_st_next;
      r_intr  <= (w_st_next == ST_REQ);
    end
  end

`ifdef IC_TIMEOUT_EN
  // A timeout in the same cycle as a TOF clear leaves the flag set.
  always_ff @(posedge IC_CLK or negedge IC_RST_N) begin
    if (!IC_RST_N) begin
      r_cnt <= 8'd0;
      r_tof <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_tof_set) r_tof <= 1'b1;
      else if (w_wr_stat && IC_DIN[7]) r_tof <= 1'b0;
    end
  end
`endif

  always_comb begin
    IC_DOUT = 8'h00;
    if (IC_PORT_ID == ADDR_MASK)      IC_DOUT = r_mask;
    else if (IC_PORT_ID == ADDR_PEND) IC_DOUT = r_pend;
    else if (IC_PORT_ID == ADDR_STAT) IC_DOUT = {w_tof, 2'b00, r_st, r_cur};
  end

  assign IC_INTR = r_intr;

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter BASE_ID, default 8'hE0: port ID of register 0; registers occupy BASE_ID..BASE_ID+2.
REQ-002 Parameter TIMEOUT, default 8'd255: REQ-state acknowledge timeout in cycles, used only when IC_TIMEOUT_EN is defined.
REQ-003 IC_CLK  in  1  the single clock; all state updates on its rising edge.
REQ-004 IC_RST_N  in  1  reset, asynchronous assert, active-low.
REQ-005 IC_IRQ  in  8  asynchronous interrupt sources; bit 0 has the highest priority.
REQ-006 IC_PORT_ID  in  8  MCU PORT_ID.
REQ-007 IC_DIN  in  8  MCU OUT_PORT data.
REQ-008 IC_IO_STRB  in  1  MCU IO_STRB; a register write occurs when it is high at a clock edge.
REQ-009 IC_DOUT  out  8  register read data, to be muxed into MCU IN_PORT.
REQ-010 IC_INTR  out  1  interrupt request to MCU INTR.

Function
REQ-011 Each IC_IRQ bit passes through a 2-flop synchronizer, then a rising-edge detector; a detected edge sets PEND[i].
REQ-012 PEND[i] is set at the 3rd rising clock edge after IC_IRQ[i] goes high; a pulse shorter than one clock period need not be captured.
REQ-013 Registers:
- offset 0 MASK (R/W; 1 = enabled).
- offset 1 PEND (read) / EOI (write).
- offset 2 STATUS (read) / ACK (write).
REQ-014 IC_DOUT is combinational:
- MASK when IC_PORT_ID==BASE_ID.
- PEND when IC_PORT_ID==BASE_ID+1.
- {TOF, 2'b0, ST[1:0], CUR[2:0]} when IC_PORT_ID==BASE_ID+2.
- 8'h00 for any other port ID.
REQ-015 A write to EOI clears the PEND bits set in IC_DIN; if the same bit is set by an edge in the same cycle, the set wins.
REQ-016 Masked bits still latch into PEND; they do not request service until unmasked.
REQ-017 The FSM state ST has three states: IDLE=2'b00, REQ=2'b01, SERV=2'b10.
REQ-018 IDLE: if (PEND & MASK) != 0, CUR is loaded with the lowest set index and the FSM moves to REQ at the next edge.
REQ-019 REQ: IC_INTR=1 (registered, decoded from state). A write to ACK moves the FSM to SERV; CUR is frozen.
REQ-020 SERV: IC_INTR=0. A write to EOI clears PEND per REQ-015 and moves the FSM to IDLE.
REQ-021 An EOI write in IDLE or REQ clears bits only, with no state change. An ACK write outside REQ is ignored.
REQ-022 If MASK[CUR] is cleared while in REQ, the FSM returns to IDLE at the next edge with PEND unchanged.
REQ-023 Back-to-back service: after an EOI, IC_INTR is high again no earlier than 2 edges later if other enabled PEND bits remain.
REQ-024 Unused state 2'b11 goes to IDLE at the next edge.

Reset
REQ-025 While IC_RST_N is low, asynchronously:
- MASK=0, PEND=0, CUR=0, TOF=0, ST=IDLE.
- synchronizer and edge flops = 0.
- timeout counter = 0.
- IC_INTR=0.
REQ-026 Reset asserted mid-service aborts the service; no pending state survives.
REQ-027 Edges on IC_IRQ lines that are already high when reset is released are not detected.

Configuration
REQ-028 Macro IC_TIMEOUT_EN.
REQ-029 When IC_TIMEOUT_EN is defined: an 8-bit counter clears on entry to REQ and increments each cycle in REQ. When the counter reaches TIMEOUT without an ACK, the FSM returns to IDLE, PEND is kept, and TOF is set. TOF is cleared by writing STATUS with IC_DIN[7]=1.
REQ-030 When IC_TIMEOUT_EN is undefined: there is no counter, the FSM stays in REQ until ACK or a mask drop, and TOF reads 0.

Verification
REQ-031 Reset, then write MASK=8'h05, pulse IRQ[2] -> PEND=8'h04 after 3 edges; INTR rises 1 edge later; STATUS=8'h0A.
REQ-032 IRQ[5] and IRQ[1] rise in the same cycle with MASK=FF -> CUR=1 first; after ACK then EOI=8'h02, CUR=5 and INTR re-asserts.
REQ-033 EOI=8'h08 written in the same cycle that an IRQ[3] edge is detected -> PEND[3] stays 1.
REQ-034 In REQ, write MASK=0 -> INTR=0 next edge, ST=IDLE, PEND unchanged.
REQ-035 With IC_TIMEOUT_EN defined and TIMEOUT=4, no ACK -> INTR drops after 4 REQ cycles, STATUS[7]=1; writing STATUS=8'h80 clears it.
REQ-036 Drive IC_RST_N low while in SERV -> all registers 0 and INTR=0 immediately, without waiting for a clock edge.
